imm_decode_stage: RTL

Registered, parametrised immediate-generation stage between instruction fetch and the decode/execute stage. It accepts one instruction per cycle over a valid/ready handshake and classifies the immediate format. It produces the fully sign- or zero-extended immediate at XLEN width and flags illegal encodings. A 2-entry skid buffer absorbs downstream back-pressure without a combinational ready path.

---
 rtl/imm_decode_stage.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// ----------------
// Immediate-generation stage sitting between instruction fetch and
// decode/execute. Each accepted instruction is classified by immediate
// format, its immediate is sign- or zero-extended to XLEN, and ill-formed
// or unsupported encodings are flagged. The result is stored in a 2-entry
// buffer so that downstream back-pressure never reaches in_ready
// combinationally.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   flush         drop every buffered entry (and any push) this cycle
//   in_valid      upstream offers in_inst / in_pc
//   in_ready      buffer has room (count < 2), taken from registers only
//   in_inst       32-bit instruction word
//   in_pc         XLEN-bit instruction address
//   out_valid     head entry is valid (count != 0)
//   out_ready     downstream consumes the head entry
//   out_inst      head instruction
//   out_pc        head pc
//   out_imm       extended immediate of the head entry
//   out_imm_type  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_illegal   head entry is unsupported or ill-formed
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter int RV64_OPS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    localparam logic [2:0] imm_none = 3'd0;
    localparam logic [2:0] imm_i    = 3'd1;
    localparam logic [2:0] imm_s    = 3'd2;
    localparam logic [2:0] imm_b    = 3'd3;
    localparam logic [2:0] imm_u    = 3'd4;
    localparam logic [2:0] imm_j    = 3'd5;
    localparam logic [2:0] imm_z    = 3'd6;

    // The 32-bit word-operation opcodes only exist on a 64-bit datapath.
    localparam bit rv64_en = (RV64_OPS != 0) && (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } dec_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        dec_t            dec;
    } entry_t;

    // Classify the immediate format and build the extended immediate.
    // The immediate is first assembled as a 32-bit value (already sign-
    // extended within 32 bits where applicable), then widened to XLEN
    // either by sign or zero extension.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t        d;
        logic [31:0] raw;
        logic        sx;
        logic [2:0]  f3;
        d.imm_type = imm_none;
        d.illegal  = 1'b0;
        raw        = 32'd0;
        sx         = 1'b0;
        f3         = inst[14:12];
        if (inst[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (inst[6:0])
                7'h33: d.imm_type = imm_none;
                7'h3B: d.illegal = !rv64_en;
                7'h13, 7'h03, 7'h67, 7'h0F: begin
                    d.imm_type = imm_i;
                    raw        = {{20{inst[31]}}, inst[31:20]};
                    sx         = 1'b1;
                end
                7'h1B: begin
                    if (rv64_en) begin
                        d.imm_type = imm_i;
                        raw        = {{20{inst[31]}}, inst[31:20]};
                        sx         = 1'b1;
                    end else begin
                        d.illegal = 1'b1;
                    end
                end
                7'h23: begin
                    d.imm_type = imm_s;
                    raw        = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    sx         = 1'b1;
                end
                7'h63: begin
                    d.imm_type = imm_b;
                    raw        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                  inst[11:8], 1'b0};
                    sx         = 1'b1;
                end
                7'h37, 7'h17: begin
                    d.imm_type = imm_u;
                    raw        = {inst[31:12], 12'd0};
                    sx         = 1'b1;
                end
                7'h6F: begin
                    d.imm_type = imm_j;
                    raw        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                  inst[30:21], 1'b0};
                    sx         = 1'b1;
                end
                7'h73: begin
                    // funct3=100 must be tested before the zimm forms (1xx).
                    if (f3 == 3'b100) begin
                        d.illegal = 1'b1;
                    end else if (f3[2]) begin
                        d.imm_type = imm_z;
                        raw        = {27'd0, inst[19:15]};
                    end else if (f3 != 3'b000) begin
                        // CSR address is an unsigned 12-bit index.
                        d.imm_type = imm_i;
                        raw        = {20'd0, inst[31:20]};
                    end else begin
                        d.imm_type = imm_none;
                    end
                end
                default: d.illegal = 1'b1;
            endcase
        end
        d.imm = sx ? XLEN'($signed(raw)) : XLEN'(raw);
        return d;
    endfunction

    logic [1:0] count_r, count_s;
    entry_t     e0_r, e1_r, e0_s, e1_s;
    entry_t     new_s;
    logic       push_s, pop_s;

    // Buffer next-state: e0 is always the head; e1 only holds the second entry.
    always_comb begin
        count_s    = count_r;
        e0_s       = e0_r;
        e1_s       = e1_r;
        new_s.inst = in_inst;
        new_s.pc   = in_pc;
        new_s.dec  = decode(in_inst);
        push_s     = in_valid && (count_r < 2'd2) && !flush;
        pop_s      = (count_r != 2'd0) && out_ready;
        if (flush) begin
            // Entries are left untouched so outputs keep their last values.
            count_s = 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        e0_s    = new_s;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        e0_s    = new_s;
                        count_s = 2'd1;
                    end else if (pop_s) begin
                        count_s = 2'd0;
                    end else if (push_s) begin
                        e1_s    = new_s;
                        count_s = 2'd2;
                    end else begin
                        count_s = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        e0_s    = e1_r;
                        count_s = 2'd1;
                    end else begin
                        count_s = 2'd2;
                    end
                end
                default: count_s = 2'd0;
            endcase
        end
    end

    // Buffer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            e0_r    <= '0;
            e1_r    <= '0;
        end else begin
            count_r <= count_s;
            e0_r    <= e0_s;
            e1_r    <= e1_s;
        end
    end

    assign in_ready     = (count_r < 2'd2);
    assign out_valid    = (count_r != 2'd0);
    assign out_inst     = e0_r.inst;
    assign out_pc       = e0_r.pc;
    assign out_imm      = e0_r.dec.imm;
    assign out_imm_type = e0_r.dec.imm_type;
    assign out_illegal  = e0_r.dec.illegal;

endmodule
